// File: rtl/vga_pixel_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_pixel_scanner                                            |
// | Description : Raster timing generator. Divides clk down to a pixel tick,    |
// |               scans the frame, presents the current coordinate to a        |
// |               pattern block, and registers the returned colour together   |
// |               with hsync, vsync and data-enable so that all VGA outputs    |
// |               lag the coordinate by exactly one pixel tick.                |
// | Ports       : clk, rst_n            - clock, async active-low reset        |
// |               o_x, o_y              - current pixel column / row           |
// |               o_active              - coordinate lies in the visible area  |
// |               o_pix_tick            - one-clk pulse where the pixel moves  |
// |               i_red/green/blue      - colour for (o_x,o_y), combinational  |
// |               o_vga_red/green/blue  - registered colour, 0 when blanking   |
// |               o_hsync, o_vsync      - registered sync, level = SYNC_POL    |
// |               o_de                  - registered data enable               |
// |               o_frame_start         - one-clk pulse as scan wraps to (0,0) |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module vga_pixel_scanner #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic signed [15:0] o_x,
  output logic signed [15:0] o_y,
  output logic               o_active,
  output logic               o_pix_tick,
  input  logic [7:0]         i_red,
  input  logic [7:0]         i_green,
  input  logic [7:0]         i_blue,
  output logic [7:0]         o_vga_red,
  output logic [7:0]         o_vga_green,
  output logic [7:0]         o_vga_blue,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic               o_frame_start
);

  // --------------------------------------------------------------------------
  // Derived timing constants
  // --------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Totals are capped at 32767, so 15 bits hold every count and the MSB of
  // the 16-bit signed coordinate outputs is always zero.
  localparam int CNT_W = 15;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if ((H_TOTAL > 32767) || (V_TOTAL > 32767)) begin : g_bad_totals
    $error("vga_pixel_scanner: H_TOTAL and V_TOTAL must be <= 32767");
  end

  if ((CLK_DIV < 1) || (CLK_DIV > 256)) begin : g_bad_clk_div
    $error("vga_pixel_scanner: CLK_DIV must lie in 1..256");
  end

  // --------------------------------------------------------------------------
  // Internal signals
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             pix_tick;
  logic             h_last;
  logic             v_last;
  logic             active;
  logic             hsync_on;
  logic             vsync_on;

  // --------------------------------------------------------------------------
  // Pixel tick divider
  // --------------------------------------------------------------------------
  // With CLK_DIV=1 the counter is a single bit stuck at zero and DIV_LAST is
  // zero, so the tick is permanently high.
  assign pix_tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Raster counters
  // --------------------------------------------------------------------------
  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + CNT_W'(1);
        end
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Region decode from the current (pre-increment) counters
  // --------------------------------------------------------------------------
  assign active   = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign hsync_on = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vsync_on = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // --------------------------------------------------------------------------
  // Output stage: samples the pattern colour and region flags for the pixel
  // currently on o_x/o_y, so everything here lags the coordinate by one tick.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vga_red   <= 8'd0;
      o_vga_green <= 8'd0;
      o_vga_blue  <= 8'd0;
      o_de        <= 1'b0;
      o_hsync     <= ~SYNC_POL;
      o_vsync     <= ~SYNC_POL;
    end else if (pix_tick) begin
      o_vga_red   <= active ? i_red   : 8'd0;
      o_vga_green <= active ? i_green : 8'd0;
      o_vga_blue  <= active ? i_blue  : 8'd0;
      o_de        <= active;
      o_hsync     <= hsync_on ? SYNC_POL : ~SYNC_POL;
      o_vsync     <= vsync_on ? SYNC_POL : ~SYNC_POL;
    end
  end

  // Registered every clk (not only on ticks) so it is a single-clk pulse,
  // landing on the same edge that moves the counters to (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= pix_tick && h_last && v_last;
    end
  end

  // --------------------------------------------------------------------------
  // Coordinate and status outputs
  // --------------------------------------------------------------------------
  assign o_x        = $signed({1'b0, h_cnt});
  assign o_y        = $signed({1'b0, v_cnt});
  assign o_active   = active;
  assign o_pix_tick = pix_tick;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_pixel_scanner                                         |
// | Description : Self-checking bench for vga_pixel_scanner. Three instances:  |
// |               default 640x480 timing (CLK_DIV=4), a tiny 12x7 raster with  |
// |               CLK_DIV=1, and the same tiny raster with CLK_DIV=3 and       |
// |               active-high sync. A reference model pushes the expected      |
// |               output set per pixel tick into a queue; a monitor pops it    |
// |               whenever the DUT ticks and compares every output.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_vga_pixel_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x; int y; int r; int g; int b;
    bit de; bit hs; bit vs; bit fs;
  } exp_t;

  // Per-instance timing table
  int p_div [3] = '{4, 1, 3};
  int p_ha  [3] = '{640, 8, 8};
  int p_hfp [3] = '{16, 1, 1};
  int p_hs  [3] = '{96, 2, 2};
  int p_hbp [3] = '{48, 1, 1};
  int p_va  [3] = '{480, 4, 4};
  int p_vfp [3] = '{10, 1, 1};
  int p_vs  [3] = '{2, 1, 1};
  int p_vbp [3] = '{33, 1, 1};
  int p_pol [3] = '{0, 0, 1};
  // Hand-computed: negedge index (from release) of first tick, clks per frame
  int first_tick_hand [3] = '{4, 1, 3};
  int frame_clk_hand  [3] = '{0, 84, 252};

  logic signed [15:0] ox [3];
  logic signed [15:0] oy [3];
  logic               act [3];
  logic               tick [3];
  logic [7:0]         ir [3];
  logic [7:0]         ig [3];
  logic [7:0]         ib;
  logic [7:0]         vr [3];
  logic [7:0]         vg [3];
  logic [7:0]         vb [3];
  logic               hs [3];
  logic               vs [3];
  logic               de [3];
  logic               fs [3];

  // Pattern block stand-in: red = x, green = y, blue constant
  assign ib = 8'hA5;
  for (genvar k = 0; k < 3; k++) begin : g_pattern
    assign ir[k] = ox[k][7:0];
    assign ig[k] = oy[k][7:0];
  end

  vga_pixel_scanner dut_a (
    .clk(clk), .rst_n(rst_n), .o_x(ox[0]), .o_y(oy[0]), .o_active(act[0]),
    .o_pix_tick(tick[0]), .i_red(ir[0]), .i_green(ig[0]), .i_blue(ib),
    .o_vga_red(vr[0]), .o_vga_green(vg[0]), .o_vga_blue(vb[0]),
    .o_hsync(hs[0]), .o_vsync(vs[0]), .o_de(de[0]), .o_frame_start(fs[0])
  );

  vga_pixel_scanner #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .o_x(ox[1]), .o_y(oy[1]), .o_active(act[1]),
    .o_pix_tick(tick[1]), .i_red(ir[1]), .i_green(ig[1]), .i_blue(ib),
    .o_vga_red(vr[1]), .o_vga_green(vg[1]), .o_vga_blue(vb[1]),
    .o_hsync(hs[1]), .o_vsync(vs[1]), .o_de(de[1]), .o_frame_start(fs[1])
  );

  vga_pixel_scanner #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .o_x(ox[2]), .o_y(oy[2]), .o_active(act[2]),
    .o_pix_tick(tick[2]), .i_red(ir[2]), .i_green(ig[2]), .i_blue(ib),
    .o_vga_red(vr[2]), .o_vga_green(vg[2]), .o_vga_blue(vb[2]),
    .o_hsync(hs[2]), .o_vsync(vs[2]), .o_de(de[2]), .o_frame_start(fs[2])
  );

  // --------------------------------------------------------------------------
  // Check bookkeeping
  // --------------------------------------------------------------------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int k, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, got, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard queues
  // --------------------------------------------------------------------------
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  task automatic sb_push(input int k, input exp_t e);
    case (k)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int k, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{default: 0};
    case (k)
      0: if (qa.size() > 0) begin e = qa.pop_front(); ok = 1'b1; end
      1: if (qb.size() > 0) begin e = qb.pop_front(); ok = 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic sb_clear(input int k);
    case (k)
      0: qa.delete();
      1: qb.delete();
      default: qc.delete();
    endcase
  endtask

  function automatic exp_t reset_exp(input int k);
    exp_t e;
    e = '{default: 0};
    e.hs = (p_pol[k] == 0);
    e.vs = (p_pol[k] == 0);
    return e;
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: counts clk edges since release, and on each pixel tick
  // pushes the outputs expected right after that tick.
  // --------------------------------------------------------------------------
  int mh [3];
  int mv [3];
  int medge [3];

  initial begin : model
    exp_t e;
    int h, v, ht, vt;
    bit a, pol;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          mh[k] = 0; mv[k] = 0; medge[k] = 0;
          sb_clear(k);
        end else begin
          medge[k]++;
          if (medge[k] % p_div[k] == 0) begin
            h   = mh[k];
            v   = mv[k];
            ht  = p_ha[k] + p_hfp[k] + p_hs[k] + p_hbp[k];
            vt  = p_va[k] + p_vfp[k] + p_vs[k] + p_vbp[k];
            pol = (p_pol[k] != 0);
            a   = (h < p_ha[k]) && (v < p_va[k]);
            e.de = a;
            e.r  = a ? (h % 256) : 0;
            e.g  = a ? (v % 256) : 0;
            e.b  = a ? 165 : 0;
            e.hs = ((h >= p_ha[k] + p_hfp[k]) && (h < p_ha[k] + p_hfp[k] + p_hs[k])) ? pol : !pol;
            e.vs = ((v >= p_va[k] + p_vfp[k]) && (v < p_va[k] + p_vfp[k] + p_vs[k])) ? pol : !pol;
            e.fs = (h == ht - 1) && (v == vt - 1);
            h++;
            if (h == ht) begin
              h = 0;
              v++;
              if (v == vt) v = 0;
            end
            e.x = h;
            e.y = v;
            mh[k] = h;
            mv[k] = v;
            sb_push(k, e);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  exp_t cur [3];
  bit   prev_tick [3];
  bit   seen_first [3];
  int   negs [3];
  int   tick_no [3];
  int   last_fs [3];
  int   fs_cnt [3];
  int   seg = 0;

  int a_hs_low = 0, a_hs_first = 0, a_de_cnt = 0, a_line_len = 0;
  int b_vs_low = 0, c_vs_high = 0;
  bit b_de_next = 1'b0;

  task automatic compare_all(input int k);
    exp_t c;
    bit a;
    c = cur[k];
    a = (c.x < p_ha[k]) && (c.y < p_va[k]);
    chk("x", k, int'(ox[k]), c.x);
    chk("y", k, int'(oy[k]), c.y);
    chk("active", k, int'(act[k]), int'(a));
    chk("de", k, int'(de[k]), int'(c.de));
    chk("hsync", k, int'(hs[k]), int'(c.hs));
    chk("vsync", k, int'(vs[k]), int'(c.vs));
    chk("frame_start", k, int'(fs[k]), int'(c.fs));
    chk("red", k, int'(vr[k]), c.r);
    chk("green", k, int'(vg[k]), c.g);
    chk("blue", k, int'(vb[k]), c.b);
  endtask

  initial begin : monitor
    exp_t e;
    bit ok, popped;
    for (int k = 0; k < 3; k++) begin
      last_fs[k] = 0; fs_cnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          cur[k] = reset_exp(k);
          prev_tick[k] = 1'b0; seen_first[k] = 1'b0;
          negs[k] = 0; tick_no[k] = 0; last_fs[k] = 0;
          compare_all(k);
        end else begin
          negs[k]++;
          popped = 1'b0;
          if (prev_tick[k]) begin
            sb_pop(k, e, ok);
            if (!ok) chk("sb_underflow", k, 0, 1);
            else begin
              cur[k] = e;
              popped = 1'b1;
              tick_no[k]++;
            end
          end
          compare_all(k);
          chk("pix_tick", k, int'(tick[k]), int'((medge[k] % p_div[k]) == p_div[k] - 1));
          if (tick[k] && !seen_first[k]) begin
            seen_first[k] = 1'b1;
            chk("first_tick_clk", k, negs[k], first_tick_hand[k]);
          end

          // Directed line/colour observations on the 640x480 instance
          if (k == 0 && popped && seg == 1 && tick_no[0] <= 800) begin
            if (!hs[0]) begin
              a_hs_low++;
              if (a_hs_first == 0) a_hs_first = tick_no[0];
            end
            if (de[0]) a_de_cnt++;
            if (ox[0] == 16'sd0 && a_line_len == 0) a_line_len = tick_no[0];
            if (tick_no[0] == 101) begin
              chk("red_at_x100", 0, int'(vr[0]), 100);
              chk("blue_active", 0, int'(vb[0]), 165);
            end
            if (tick_no[0] == 701) begin
              chk("red_blank", 0, int'(vr[0]), 0);
              chk("blue_blank", 0, int'(vb[0]), 0);
            end
          end

          if (k == 1 && popped) begin
            if (b_de_next) begin
              chk("de_after_wrap", 1, int'(de[1]), 1);
              b_de_next = 1'b0;
            end
            if (seg == 1 && tick_no[1] <= 84 && !vs[1]) b_vs_low++;
          end
          if (k == 2 && popped && seg == 1 && tick_no[2] <= 84 && vs[2]) c_vs_high++;

          // Wrap corner on the small rasters
          if (k > 0 && fs[k]) begin
            chk("fs_x_zero", k, int'(ox[k]), 0);
            chk("fs_y_zero", k, int'(oy[k]), 0);
            chk("fs_de_low", k, int'(de[k]), 0);
            if (last_fs[k] > 0) chk("frame_clks", k, negs[k] - last_fs[k], frame_clk_hand[k]);
            last_fs[k] = negs[k];
            fs_cnt[k]++;
            if (k == 1) b_de_next = 1'b1;
          end

          cur[k].fs = 1'b0;
          prev_tick[k] = tick[k];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus: reset, long run, mid-frame reset (during dut_a hsync), rerun
  // --------------------------------------------------------------------------
  initial begin : stim
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b1;
    seg = 1;
    repeat (5900) @(posedge clk);
    #3 rst_n = 1'b0;
    seg = 2;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    #1;
    chk("line_ticks", 0, a_line_len, 800);
    chk("hsync_low_ticks", 0, a_hs_low, 96);
    chk("hsync_first_tick", 0, a_hs_first, 657);
    chk("de_ticks", 0, a_de_cnt, 640);
    chk("vsync_low_ticks", 1, b_vs_low, 12);
    chk("vsync_high_ticks", 2, c_vs_high, 12);
    chk("frame_starts_seen", 1, int'(fs_cnt[1] >= 2), 1);
    chk("frame_starts_seen", 2, int'(fs_cnt[2] >= 2), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
